byte_unstriping: RTL and testbench
==================================

Name: byte_unstriping

Overview:
Receive-side counterpart of the two-lane byte striper. Accepts 32-bit words from lane 0 and lane 1, buffers each lane in a small FIFO to absorb inter-lane skew, and re-serialises the words into one stream in strict lane-0, lane-1 alternation. Sits between the per-lane receive path and the PHY-to-link interface, single clock domain clk_2f.

Parameters:
DATA_W, 32, width of lane and output words
FIFO_DEPTH, 4, entries per lane FIFO (power of 2, >= 2)
PTR_W, 2, log2(FIFO_DEPTH)

Ports:
clk_2f  input  1  sole clock, all state updates on rising edge
reset  input  1  synchronous, active-high
lane_0  input  DATA_W  lane 0 word
valid_0  input  1  one-cycle strobe per lane 0 word (exactly one push per asserted cycle)
lane_1  input  DATA_W  lane 1 word
valid_1  input  1  one-cycle strobe per lane 1 word
data_out  output  DATA_W  merged word, 0 when valid_out=0
valid_out  output  1  data_out qualifier
error  output  1  sticky overflow flag

Behaviour:
- Reset (sampled high on an edge): state=IDLE, sel=0, both FIFOs empty (pointers/counts 0), data_out=0, valid_out=0, error=0. Reset mid-stream discards all buffered words; inputs strobed in the reset cycle are ignored.
- Push: per lane k, if valid_k=1 then the word is written if the FIFO is not full OR a pop from that same FIFO occurs in the same cycle. Otherwise the word is dropped, error<=1 and state<=ERR on that edge.
- Each FIFO: circular buffer, wr/rd pointers PTR_W bits wrapping modulo FIFO_DEPTH, count PTR_W+1 bits, 0..FIFO_DEPTH. Simultaneous push+pop leaves count unchanged. Pop reads the entry that was head before the edge; a word pushed at edge t is poppable no earlier than edge t+1 (no write-through).
- FSM, one registered state:
  IDLE: valid_out<=0, data_out<=0. If fifo0 non-empty: pop fifo0, data_out<=head0, valid_out<=1, sel<=1, state<=RUN.
  RUN: if fifo[sel] non-empty: pop it, data_out<=head, valid_out<=1, sel<=~sel. Else valid_out<=0, data_out<=0, sel held (waits for the lagging lane; never skips a lane).
  ERR: valid_out<=0, data_out<=0, error=1, no pops, pushes ignored; exit only via reset.
- Overflow takes priority over a pop in the same cycle: state goes to ERR, and the output for that edge is valid_out=0.
- Latency: a word pushed at edge t appears on data_out after edge t+1 at the earliest. Steady-state throughput is one word per cycle.
- Ordering: output order is L0[0], L1[0], L0[1], L1[1], ... regardless of arrival skew, as long as skew is < FIFO_DEPTH words.
- Odd-length stream (final word on lane 0 only): the word is output, then sel=1 and the block idles in RUN awaiting lane 1. The next lane-1 word continues the alternation.

Decomposition:
- Shared PHY package: DATA_W, FIFO_DEPTH, PTR_W defaults; state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_ERR=2'd2.
- Sub-module unstripe_lane_fifo (instantiated twice): push/pop/din/dout/empty/full/count with the same-cycle push-when-full-with-pop rule. The top level holds the FSM, sel, the output registers and the error flag.

Test Plan:
- Reset, then L0=0xA0 strobe at cyc1, L1=0xB0 at cyc2, L0=0xA1 at cyc3, L1=0xB1 at cyc4 -> valid_out high cyc2..5 with data_out 0xA0, 0xB0, 0xA1, 0xB1; error=0.
- Skew: L1 words 0xB0, 0xB1 arrive 3 cycles before L0 words 0xA0, 0xA1 -> output still 0xA0, 0xB0, 0xA1, 0xB1; valid_out stays low until 0xA0 is poppable.
- Overflow: five L1 strobes with no L0 data -> the 5th word is dropped, error=1 and stays 1, valid_out=0 thereafter; reset clears error and returns to IDLE.
- Full-with-pop: fifo0 holds 4 entries in RUN with sel=0 and a valid_0 strobe in the same cycle -> word accepted, count stays 4, error=0.
- Odd stream: L0=0x11 only -> data_out=0x11 for one cycle, then valid_out=0. A later L1=0x22, L0=0x33 -> outputs 0x22, then 0x33.
- Reset mid-stream with 2 words buffered -> valid_out=0 and data_out=0 after the reset edge; the old words never appear.

Source files
------------

// File: rtl/byte_unstriping_pkg.sv
// Shared PHY definitions for the two-lane byte unstriper: widths, depths and FSM encoding.
package byte_unstriping_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned PTR_W      = 2;
  localparam int unsigned NUM_LANES  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } lane_word_t;

endpackage

// File: rtl/byte_unstriping_if.sv
// Lane inputs and merged-stream outputs of the unstriper, bundled for port connection.
interface byte_unstriping_if;
  import byte_unstriping_pkg::*;

  logic [DATA_W-1:0] lane_0;
  logic              valid_0;
  logic [DATA_W-1:0] lane_1;
  logic              valid_1;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              error;

  modport master (
    output lane_0, valid_0, lane_1, valid_1,
    input  data_out, valid_out, error
  );

  modport slave (
    input  lane_0, valid_0, lane_1, valid_1,
    output data_out, valid_out, error
  );

endinterface

// File: rtl/unstripe_lane_fifo.sv
// Per-lane skew FIFO; a push into a full FIFO is accepted only when the same FIFO pops that cycle.
module unstripe_lane_fifo
  import byte_unstriping_pkg::*;
#(
  parameter int unsigned DW    = DATA_W,
  parameter int unsigned DEPTH = FIFO_DEPTH,
  parameter int unsigned PW    = PTR_W
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [PW:0]   count_o
);

  localparam int unsigned CNT_W = PW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;

  // Pointer and occupancy update; push+pop leaves the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/byte_unstriping.sv
// Merges lane 0 / lane 1 words into one stream in strict L0, L1 alternation, absorbing skew per lane.
module byte_unstriping
  import byte_unstriping_pkg::*;
(
  input  logic              clk_2f,
  input  logic              reset,
  byte_unstriping_if.slave  bus
);

  state_e            state_q, state_d;
  logic              sel_q, sel_d;
  logic              error_q, error_d;
  lane_word_t        out_q, out_d;

  logic [DATA_W-1:0] head   [NUM_LANES];
  logic [NUM_LANES-1:0] empty, full, push, pop_want, pop, strobe, overflow;
  logic [PTR_W:0]    count  [NUM_LANES];
  logic [DATA_W-1:0] lane_d [NUM_LANES];

  assign strobe    = {bus.valid_1, bus.valid_0};
  assign lane_d[0] = bus.lane_0;
  assign lane_d[1] = bus.lane_1;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign push[k] = strobe[k] && (state_q != ST_ERR);

    unstripe_lane_fifo #(
      .DW    (DATA_W),
      .DEPTH (FIFO_DEPTH),
      .PW    (PTR_W)
    ) u_fifo (
      .clk_i   (clk_2f),
      .rst_i   (reset),
      .push_i  (push[k]),
      .pop_i   (pop[k]),
      .din_i   (lane_d[k]),
      .dout_o  (head[k]),
      .empty_o (empty[k]),
      .full_o  (full[k]),
      .count_o (count[k])
    );
  end

  // Intended pop per lane, before overflow arbitration.
  always_comb begin
    pop_want = '0;
    case (state_q)
      ST_IDLE: pop_want[0] = !empty[0];
      ST_RUN:  pop_want[sel_q] = !empty[sel_q];
      default: pop_want = '0;
    endcase
  end

  // A strobe into a full FIFO that is not popping this cycle is a drop.
  assign overflow = push & full & ~pop_want;
  assign pop      = (|overflow) ? '0 : pop_want;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    error_d = error_q;
    out_d   = '0;
    if (|overflow) begin
      state_d = ST_ERR;
      error_d = 1'b1;
    end else if (|pop) begin
      out_d.valid = 1'b1;
      out_d.data  = head[sel_q];
      sel_d       = ~sel_q;
      state_d     = ST_RUN;
    end
  end

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= 1'b0;
      error_q <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      error_q <= error_d;
      out_q   <= out_d;
    end
  end

  assign bus.data_out  = out_q.data;
  assign bus.valid_out = out_q.valid;
  assign bus.error     = error_q;

endmodule

// File: tb/tb_byte_unstriping.sv
// Directed, cycle-accurate bench for byte_unstriping: vector table plus hand-built corner sequences.
module tb_byte_unstriping;
  import byte_unstriping_pkg::*;

  typedef struct {
    logic              rst;
    logic              v0;
    logic [DATA_W-1:0] d0;
    logic              v1;
    logic [DATA_W-1:0] d1;
    logic              ev;
    logic [DATA_W-1:0] ed;
    logic              ee;
  } vec_t;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;
  vec_t vecs [$];

  byte_unstriping_if bus ();

  byte_unstriping dut (
    .clk_2f (clk),
    .reset  (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic v0, input logic [DATA_W-1:0] d0,
                              input logic v1, input logic [DATA_W-1:0] d1,
                              input logic ev, input logic [DATA_W-1:0] ed, input logic ee);
    vec_t v;
    v.rst = r; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
    v.ev = ev; v.ed = ed; v.ee = ee;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
    else n_pass++;
  endtask

  // Drive one cycle of inputs, let the edge happen, then check the registered outputs.
  task automatic step(input string nm, input vec_t v);
    rst         = v.rst;
    bus.valid_0 = v.v0;
    bus.lane_0  = v.d0;
    bus.valid_1 = v.v1;
    bus.lane_1  = v.d1;
    @(posedge clk);
    #1;
    chk({nm, ".valid_out"}, DATA_W'(bus.valid_out), DATA_W'(v.ev));
    chk({nm, ".data_out"},  bus.data_out,           v.ed);
    chk({nm, ".error"},     DATA_W'(bus.error),     DATA_W'(v.ee));
  endtask

  task automatic run_seq(input string nm, input vec_t s [$]);
    foreach (s[i]) step($sformatf("%s[%0d]", nm, i), s[i]);
  endtask

  initial begin
    vec_t seq [$];
    n_total = 0;
    n_pass  = 0;
    rst = 1'b1;
    bus.valid_0 = 1'b0; bus.lane_0 = '0;
    bus.valid_1 = 1'b0; bus.lane_1 = '0;

    // Basic alternation
    vecs.push_back(mk(1, 0, 0,     0, 0,     0, 0,     0));
    vecs.push_back(mk(0, 1, 'hA0,  0, 0,     0, 0,     0));
    vecs.push_back(mk(0, 0, 0,     1, 'hB0,  1, 'hA0,  0));
    vecs.push_back(mk(0, 1, 'hA1,  0, 0,     1, 'hB0,  0));
    vecs.push_back(mk(0, 0, 0,     1, 'hB1,  1, 'hA1,  0));
    vecs.push_back(mk(0, 0, 0,     0, 0,     1, 'hB1,  0));
    vecs.push_back(mk(0, 0, 0,     0, 0,     0, 0,     0));
    // Lane 1 leads lane 0 by three cycles
    vecs.push_back(mk(1, 0, 0,     0, 0,     0, 0,     0));
    vecs.push_back(mk(0, 0, 0,     1, 'hB0,  0, 0,     0));
    vecs.push_back(mk(0, 0, 0,     1, 'hB1,  0, 0,     0));
    vecs.push_back(mk(0, 0, 0,     0, 0,     0, 0,     0));
    vecs.push_back(mk(0, 1, 'hA0,  0, 0,     0, 0,     0));
    vecs.push_back(mk(0, 1, 'hA1,  0, 0,     1, 'hA0,  0));
    vecs.push_back(mk(0, 0, 0,     0, 0,     1, 'hB0,  0));
    vecs.push_back(mk(0, 0, 0,     0, 0,     1, 'hA1,  0));
    vecs.push_back(mk(0, 0, 0,     0, 0,     1, 'hB1,  0));
    vecs.push_back(mk(0, 0, 0,     0, 0,     0, 0,     0));
    // Odd-length stream then resumption on lane 1
    vecs.push_back(mk(1, 0, 0,     0, 0,     0, 0,     0));
    vecs.push_back(mk(0, 1, 'h11,  0, 0,     0, 0,     0));
    vecs.push_back(mk(0, 0, 0,     0, 0,     1, 'h11,  0));
    vecs.push_back(mk(0, 0, 0,     0, 0,     0, 0,     0));
    vecs.push_back(mk(0, 1, 'h33,  0, 0,     0, 0,     0));
    vecs.push_back(mk(0, 0, 0,     1, 'h22,  0, 0,     0));
    vecs.push_back(mk(0, 0, 0,     0, 0,     1, 'h22,  0));
    vecs.push_back(mk(0, 0, 0,     0, 0,     1, 'h33,  0));
    vecs.push_back(mk(0, 0, 0,     0, 0,     0, 0,     0));
    // Full lane-0 FIFO accepts a strobe while it is being popped
    vecs.push_back(mk(1, 0, 0,     0, 0,     0, 0,     0));
    vecs.push_back(mk(0, 1, 'hF0,  0, 0,     0, 0,     0));
    vecs.push_back(mk(0, 0, 0,     0, 0,     1, 'hF0,  0));
    vecs.push_back(mk(0, 1, 'hC0,  0, 0,     0, 0,     0));
    vecs.push_back(mk(0, 1, 'hC1,  0, 0,     0, 0,     0));
    vecs.push_back(mk(0, 1, 'hC2,  0, 0,     0, 0,     0));
    vecs.push_back(mk(0, 1, 'hC3,  0, 0,     0, 0,     0));
    vecs.push_back(mk(0, 0, 0,     1, 'hD1,  0, 0,     0));
    vecs.push_back(mk(0, 0, 0,     0, 0,     1, 'hD1,  0));
    vecs.push_back(mk(0, 1, 'hC4,  0, 0,     1, 'hC0,  0));
    vecs.push_back(mk(0, 0, 0,     1, 'hD2,  0, 0,     0));
    vecs.push_back(mk(0, 0, 0,     1, 'hD3,  1, 'hD2,  0));
    vecs.push_back(mk(0, 0, 0,     1, 'hD4,  1, 'hC1,  0));
    vecs.push_back(mk(0, 0, 0,     1, 'hD5,  1, 'hD3,  0));
    vecs.push_back(mk(0, 0, 0,     0, 0,     1, 'hC2,  0));
    vecs.push_back(mk(0, 0, 0,     0, 0,     1, 'hD4,  0));
    vecs.push_back(mk(0, 0, 0,     0, 0,     1, 'hC3,  0));
    vecs.push_back(mk(0, 0, 0,     0, 0,     1, 'hD5,  0));
    vecs.push_back(mk(0, 0, 0,     0, 0,     1, 'hC4,  0));
    vecs.push_back(mk(0, 0, 0,     0, 0,     0, 0,     0));

    for (int i = 0; i < vecs.size(); i++) step($sformatf("vec%0d", i), vecs[i]);

    // Overflow on lane 1 is sticky; ERR ignores pushes; reset recovers to IDLE
    seq = {};
    seq.push_back(mk(1, 0, 0,     0, 0,     0, 0,     0));
    seq.push_back(mk(0, 0, 0,     1, 'hE0,  0, 0,     0));
    seq.push_back(mk(0, 0, 0,     1, 'hE1,  0, 0,     0));
    seq.push_back(mk(0, 0, 0,     1, 'hE2,  0, 0,     0));
    seq.push_back(mk(0, 0, 0,     1, 'hE3,  0, 0,     0));
    seq.push_back(mk(0, 0, 0,     1, 'hE4,  0, 0,     1));
    seq.push_back(mk(0, 1, 'h55,  0, 0,     0, 0,     1));
    seq.push_back(mk(0, 0, 0,     0, 0,     0, 0,     1));
    seq.push_back(mk(0, 0, 0,     0, 0,     0, 0,     1));
    seq.push_back(mk(1, 0, 0,     0, 0,     0, 0,     0));
    seq.push_back(mk(0, 1, 'h66,  0, 0,     0, 0,     0));
    seq.push_back(mk(0, 0, 0,     0, 0,     1, 'h66,  0));
    run_seq("ovf", seq);

    // Lane-1 overflow while lane 0 is due to pop: the pop is suppressed
    seq = {};
    seq.push_back(mk(1, 0, 0,     0, 0,     0, 0,     0));
    seq.push_back(mk(0, 1, 'h70,  0, 0,     0, 0,     0));
    seq.push_back(mk(0, 0, 0,     1, 'h80,  1, 'h70,  0));
    seq.push_back(mk(0, 0, 0,     1, 'h81,  1, 'h80,  0));
    seq.push_back(mk(0, 0, 0,     1, 'h82,  0, 0,     0));
    seq.push_back(mk(0, 0, 0,     1, 'h83,  0, 0,     0));
    seq.push_back(mk(0, 0, 0,     1, 'h84,  0, 0,     0));
    seq.push_back(mk(0, 1, 'h71,  0, 0,     0, 0,     0));
    seq.push_back(mk(0, 0, 0,     1, 'h85,  0, 0,     1));
    seq.push_back(mk(0, 0, 0,     0, 0,     0, 0,     1));
    run_seq("ovf_prio", seq);

    // Reset with two words buffered; strobe in the reset cycle is ignored
    seq = {};
    seq.push_back(mk(1, 0, 0,     0, 0,     0, 0,     0));
    seq.push_back(mk(0, 1, 'h90,  0, 0,     0, 0,     0));
    seq.push_back(mk(0, 1, 'h91,  0, 0,     1, 'h90,  0));
    seq.push_back(mk(0, 1, 'h92,  0, 0,     0, 0,     0));
    seq.push_back(mk(1, 1, 'h93,  1, 'h9B,  0, 0,     0));
    seq.push_back(mk(0, 0, 0,     0, 0,     0, 0,     0));
    seq.push_back(mk(0, 0, 0,     0, 0,     0, 0,     0));
    seq.push_back(mk(0, 1, 'hA5,  0, 0,     0, 0,     0));
    seq.push_back(mk(0, 0, 0,     1, 'hB5,  1, 'hA5,  0));
    seq.push_back(mk(0, 0, 0,     0, 0,     1, 'hB5,  0));
    seq.push_back(mk(0, 0, 0,     0, 0,     0, 0,     0));
    run_seq("rst_mid", seq);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
